mux_key_with_default_reg: RTL and testbench
===========================================

// Module: mux_key_with_default_reg
// PURPOSE
// - Key-indexed lookup mux with default: compares a KEY_LEN selector against NR_KEY packed {key,data} pairs.
// - Drives the matching data, or default_out when no key matches.
// - Generic operation selector for datapath blocks; e.g. ALU result select with 10 ops, 4-bit key, 32-bit data.
// - Provides a combinational result plus a registered copy for pipelined users.
// PARAMETERS
// - NR_KEY    10  number of {key,data} pairs in lut (>=1)
// - KEY_LEN    4  selector/key width in bits (>=1)
// - DATA_LEN  32  data/output width in bits (>=1)
// PORTS
// - clk          in   1                          clock, rising-edge active
// - rst          in   1                          reset, asynchronous, active-high
// - in_valid     in   1                          capture enable for registered outputs
// - key          in   KEY_LEN                    selector
// - default_out  in   DATA_LEN                   value when no entry matches
// - lut          in   NR_KEY*(KEY_LEN+DATA_LEN)  packed pairs, see BEHAVIOUR
// - out          out  DATA_LEN                   combinational lookup result
// - hit          out  1                          combinational: some entry key == key
// - out_q        out  DATA_LEN                   registered lookup result
// - hit_q        out  1                          registered hit
// - out_valid    out  1                          registered in_valid
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high (clk, rst).
// - PAIR_LEN = KEY_LEN+DATA_LEN. Slot i = lut[PAIR_LEN*(i+1)-1 -: PAIR_LEN].
//   Each slot is {key_i, data_i}, with the key in the upper KEY_LEN bits.
// - Concatenation order: the first-listed pair in a {k0,d0,k1,d1,...} concatenation lands in slot NR_KEY-1 (MSBs).
// - Match: match_i = (key_i == key). hit = |match.
// - Priority on duplicate keys: the highest slot index (first-listed pair) wins. Data from different slots is never ORed.
// - out = data of winning slot if hit, else default_out. No X-propagation tricks; purely combinational, zero latency.
// - Registers, on async rst assertion (no clock needed): out_q=0, hit_q=0, out_valid=0. They stay 0 while rst=1.
// - Each rising clk with rst=0:
//   - out_valid <= in_valid.
//   - if in_valid: out_q <= out, hit_q <= hit.
//   - else out_q/hit_q hold their previous values.
// - Latency: out/hit 0 cycles; out_q/hit_q/out_valid 1 cycle after the sampling edge.
// - Reset mid-operation: registered outputs clear immediately. The combinational out/hit continue to follow inputs.
// - Boundaries:
//   - key not present in any slot -> default_out.
//   - all slots share a key -> slot NR_KEY-1 data.
//   - NR_KEY=1 is legal.
//   - full-width all-ones key matches only a literal all-ones entry.
// - No internal state other than the three output registers; no handshake back-pressure.
// TESTING (NR_KEY=10, KEY_LEN=4, DATA_LEN=32; slot i key=i, data=32'h100+i unless stated)
// - rst=1 asynchronously mid-cycle -> out_q=0, hit_q=0, out_valid=0 immediately, before any clk edge.
// - key=4'd3, in_valid=1 -> out=32'h103, hit=1 same cycle; after next edge out_q=32'h103, hit_q=1, out_valid=1.
// - key=4'hF, default_out=32'hDEADBEEF -> out=32'hDEADBEEF, hit=0; registered next edge.
// - Slots 9 and 2 both key=4'd5 (data 32'hAAAA0000 / 32'h5555FFFF), key=5 -> out=32'hAAAA0000 (no OR).
// - out_q=32'h103 held, in_valid=0, key changed to 4'd7 -> out=32'h107 but out_q stays 32'h103, out_valid=0 next edge.
// - Exhaustive sweep key=0..15 with random default_out -> out matches reference model every cycle; out_q lags by 1.

Source files
------------

// File: rtl/mux_key_with_default_reg.sv
// Key-indexed lookup mux with default: out/hit are combinational (0 cycles), out_q/hit_q/out_valid one cycle later.
// No backpressure; in_valid only gates capture into the output registers.
module mux_key_with_default_reg #(
  parameter int NR_KEY   = 10,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [DATA_LEN-1:0]                   default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic [DATA_LEN-1:0]                   out,
  output logic                                  hit,
  output logic [DATA_LEN-1:0]                   out_q,
  output logic                                  hit_q,
  output logic                                  out_valid
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  slot_key [NR_KEY];
  logic [DATA_LEN-1:0] slot_dat [NR_KEY];

  for (genvar g = 0; g < NR_KEY; g++) begin : g_slot
    assign slot_key[g] = lut[PAIR_LEN*(g+1)-1 -: KEY_LEN];
    assign slot_dat[g] = lut[PAIR_LEN*g +: DATA_LEN];
  end

  // Ascending scan so the highest matching slot is the last assignment and wins.
  always_comb begin
    out = default_out;
    hit = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (slot_key[i] == key) begin
        out = slot_dat[i];
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      hit_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
        hit_q <= hit;
      end
    end
  end

endmodule

// File: tb/tb_mux_key_with_default_reg.sv
// Randomized bench for mux_key_with_default_reg against a first-match-from-top lookup model.
module tb_mux_key_with_default_reg;

  localparam int NK = 10;
  localparam int KL = 4;
  localparam int DL = 32;
  localparam int PL = KL + DL;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [KL-1:0]     key;
  logic [DL-1:0]     default_out;
  logic [NK*PL-1:0]  lut;
  logic [DL-1:0]     out;
  logic              hit;
  logic [DL-1:0]     out_q;
  logic              hit_q;
  logic              out_valid;

  logic [KL-1:0] tk [NK];
  logic [DL-1:0] td [NK];

  logic [DL-1:0] exp_oq;
  logic          exp_hq;
  logic          exp_ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_key_with_default_reg #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .key(key),
    .default_out(default_out), .lut(lut), .out(out), .hit(hit),
    .out_q(out_q), .hit_q(hit_q), .out_valid(out_valid)
  );

  always_comb begin
    lut = '0;
    for (int i = 0; i < NK; i++) lut[PL*(i+1)-1 -: PL] = {tk[i], td[i]};
  end

  task automatic chk(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: search from the top slot down, first key match supplies the data.
  task automatic ref_lookup(input logic [KL-1:0] k, input logic [DL-1:0] dflt,
                            output logic [DL-1:0] o, output logic h);
    o = dflt;
    h = 1'b0;
    for (int i = NK-1; i >= 0; i--) begin
      if (tk[i] == k) begin
        o = td[i];
        h = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_default_table();
    for (int i = 0; i < NK; i++) begin
      tk[i] = KL'(i);
      td[i] = 32'h100 + 32'(i);
    end
  endtask

  task automatic apply(input logic [KL-1:0] k, input logic [DL-1:0] dflt, input logic vld);
    logic [DL-1:0] m_o;
    logic          m_h;
    @(negedge clk);
    key = k; default_out = dflt; in_valid = vld;
    #1;
    ref_lookup(k, dflt, m_o, m_h);
    chk("out", out, m_o);
    chk("hit", 32'(hit), 32'(m_h));
    if (vld) begin
      exp_oq = m_o;
      exp_hq = m_h;
    end
    exp_ov = vld;
    @(posedge clk);
    #1;
    chk("out_q", out_q, exp_oq);
    chk("hit_q", 32'(hit_q), 32'(exp_hq));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; key = '0; default_out = '0;
    load_default_table();
    exp_oq = '0; exp_hq = 1'b0; exp_ov = 1'b0;
    #1;
    chk("rst_out_q", out_q, 32'h0);
    chk("rst_hit_q", 32'(hit_q), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic hit, then hold while in_valid low.
    apply(4'd3, 32'h0, 1'b1);
    chk("hit3_out_q", out_q, 32'h103);
    apply(4'd7, 32'h0, 1'b0);
    chk("hold_out", out, 32'h107);
    chk("hold_out_q", out_q, 32'h103);
    chk("hold_out_valid", 32'(out_valid), 32'h0);

    // Miss returns default.
    apply(4'hF, 32'hDEADBEEF, 1'b1);
    chk("miss_out_q", out_q, 32'hDEADBEEF);
    chk("miss_hit_q", 32'(hit_q), 32'h0);

    // Exhaustive key sweep with random defaults.
    for (int k = 0; k < 16; k++) apply(KL'(k), $urandom, 1'b1);

    // Duplicate keys: top slot wins, never ORed.
    tk[9] = 4'd5; td[9] = 32'hAAAA0000;
    tk[2] = 4'd5; td[2] = 32'h5555FFFF;
    apply(4'd5, 32'h12345678, 1'b1);
    chk("dup_out_q", out_q, 32'hAAAA0000);

    // All slots share one key.
    for (int i = 0; i < NK; i++) begin tk[i] = 4'hA; td[i] = $urandom; end
    apply(4'hA, 32'h0, 1'b1);
    chk("allsame_out_q", out_q, td[NK-1]);

    // All-ones key matches only a literal all-ones entry.
    load_default_table();
    apply(4'hF, 32'hCAFEF00D, 1'b1);
    tk[4] = 4'hF;
    apply(4'hF, 32'hCAFEF00D, 1'b1);
    chk("ones_out_q", out_q, 32'h104);

    // Mid-cycle asynchronous reset.
    apply(4'd6, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_q", out_q, 32'h0);
    chk("arst_hit_q", 32'(hit_q), 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_comb_out", out, 32'h106);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_hold_out_q", out_q, 32'h0);
    chk("arst_hold_out_valid", 32'(out_valid), 32'h0);
    exp_oq = '0; exp_hq = 1'b0; exp_ov = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized tables and traffic.
    for (int n = 0; n < 300; n++) begin
      if (n % 25 == 0) begin
        for (int i = 0; i < NK; i++) begin
          tk[i] = KL'($urandom_range(0, 15));
          td[i] = $urandom;
        end
      end
      apply(KL'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
